// File: rtl/ts_link_monitor_if.sv
// Strobe/acknowledge register bus used across the TS firmware.
// The master drives the strobes; the slave answers with acks and read data.
interface ts_link_monitor_if;
  logic        axi_wstr;
  logic        axi_rstr;
  logic [9:0]  axi_waddr;
  logic [9:0]  axi_raddr;
  logic [31:0] axi_din;
  logic        axi_wack;
  logic        axi_rack;
  logic [31:0] axi_dout;

  modport master (
    output axi_wstr, axi_rstr, axi_waddr, axi_raddr, axi_din,
    input  axi_wack, axi_rack, axi_dout
  );

  modport slave (
    input  axi_wstr, axi_rstr, axi_waddr, axi_raddr, axi_din,
    output axi_wack, axi_rack, axi_dout
  );
endinterface

// File: rtl/ts_link_monitor.sv
// Per-link error/word counters, lock tracking and a shared triggered spy buffer
// for the trigger-scintillator receive links, exposed on the register bus.
module ts_link_monitor #(
  parameter int NUM_LINKS  = 2,
  parameter int SPY_DEPTH  = 64,
  parameter int LOCK_COUNT = 255
) (
  input  logic                     axi_clk,
  input  logic                     reset,
  input  logic [16*NUM_LINKS-1:0]  rx_d,
  input  logic [2*NUM_LINKS-1:0]   rx_k,
  input  logic [NUM_LINKS-1:0]     rx_err,
  input  logic [NUM_LINKS-1:0]     rx_valid,
  output logic [NUM_LINKS-1:0]     link_up,
  ts_link_monitor_if.slave         bus
);

  localparam int AW = $clog2(SPY_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(SPY_DEPTH - 1);
  localparam logic [15:0]   LOCK_C   = 16'(LOCK_COUNT);
  localparam logic [15:0]   LOCK_M1  = 16'(LOCK_COUNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [2:0]  spy_sel;
  logic [1:0]  spy_mode;
  logic [1:0]  ctl1;
  logic [1:0]  wcnt;
  logic [1:0]  rcnt;
  logic        wr_commit;
  logic        arm_pulse;
  logic        clr_pulse;
  logic [1:0]  spy_state;
  logic [PW-1:0] spy_ptr;
  logic [31:0] rdata;
  logic [31:0] sts1;
  logic        unused_din;

  logic [NUM_LINKS-1:0][31:0] err_cnt;
  logic [NUM_LINKS-1:0][31:0] wrd_cnt;
  logic [NUM_LINKS-1:0][15:0] run_cnt;

  logic [18:0] spy_ram [SPY_DEPTH];
  logic        s_vld, s_err, s_trig, ram_we;
  logic [15:0] s_d;
  logic [1:0]  s_k;

  assign wr_commit  = bus.axi_wstr && (wcnt == 2'd1);
  assign arm_pulse  = ctl1[0];
  assign clr_pulse  = ctl1[1];
  assign unused_din = ^{bus.axi_din[31:6], bus.axi_din[3]};

  // Write handshake: count strobe-high edges, commit once on the second.
  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      wcnt         <= 2'd0;
      bus.axi_wack <= 1'b0;
    end else if (!bus.axi_wstr) begin
      wcnt         <= 2'd0;
      bus.axi_wack <= 1'b0;
    end else begin
      if (wcnt != 2'd3) wcnt <= wcnt + 2'd1;
      if (wcnt == 2'd2) bus.axi_wack <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      spy_sel  <= 3'd0;
      spy_mode <= 2'd0;
      ctl1     <= 2'd0;
    end else begin
      ctl1 <= 2'd0;
      if (wr_commit) begin
        case (bus.axi_waddr)
          10'h000: begin
            spy_sel  <= bus.axi_din[2:0];
            spy_mode <= bus.axi_din[5:4];
          end
          10'h001: ctl1 <= bus.axi_din[1:0];
          default: ;
        endcase
      end
    end
  end

  // Read handshake: data from the second strobe edge, ack on the fourth.
  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      rcnt         <= 2'd0;
      bus.axi_rack <= 1'b0;
      bus.axi_dout <= 32'd0;
    end else if (!bus.axi_rstr) begin
      rcnt         <= 2'd0;
      bus.axi_rack <= 1'b0;
      bus.axi_dout <= 32'd0;
    end else begin
      if (rcnt != 2'd3) rcnt <= rcnt + 2'd1;
      if (rcnt == 2'd3) bus.axi_rack <= 1'b1;
      bus.axi_dout <= (rcnt != 2'd0) ? rdata : 32'd0;
    end
  end

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
      wrd_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (clr_pulse) begin
          err_cnt[i] <= 32'd0;
          wrd_cnt[i] <= 32'd0;
        end else if (rx_valid[i]) begin
          wrd_cnt[i] <= sat_inc(wrd_cnt[i]);
          if (rx_err[i]) err_cnt[i] <= sat_inc(err_cnt[i]);
        end
      end
    end
  end

  // Lock tracker: the run counter parks at LOCK_COUNT once the link is up.
  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
      link_up <= '0;
    end else begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (rx_valid[i] && rx_err[i]) begin
          run_cnt[i] <= 16'd0;
          link_up[i] <= 1'b0;
        end else if (rx_valid[i] && run_cnt[i] != LOCK_C) begin
          run_cnt[i] <= run_cnt[i] + 16'd1;
          if (run_cnt[i] == LOCK_M1) link_up[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_vld = 1'b0;
    s_err = 1'b0;
    s_d   = 16'd0;
    s_k   = 2'd0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (spy_sel == 3'(i)) begin
        s_vld = rx_valid[i];
        s_err = rx_err[i];
        s_d   = rx_d[16*i +: 16];
        s_k   = rx_k[2*i +: 2];
      end
    end
    case (spy_mode)
      2'd1:    s_trig = s_err;
      2'd2:    s_trig = (s_k == 2'b00);
      default: s_trig = 1'b1;
    endcase
    ram_we = !arm_pulse && s_vld &&
             ((spy_state == S_ARMED && s_trig) || spy_state == S_CAPT);
  end

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      spy_state <= S_IDLE;
      spy_ptr   <= '0;
    end else if (arm_pulse) begin
      spy_state <= S_ARMED;
      spy_ptr   <= '0;
    end else if (ram_we) begin
      spy_ptr <= spy_ptr + PW'(1);
      if (spy_state == S_ARMED)   spy_state <= S_CAPT;
      else if (spy_ptr == PTR_LAST) spy_state <= S_DONE;
    end
  end

  // Spy RAM carries no reset so it can map onto block/distributed memory.
  always_ff @(posedge axi_clk) begin
    if (ram_we) spy_ram[spy_ptr[AW-1:0]] <= {s_err, s_k, s_d};
  end

  always_comb begin
    sts1 = 32'd0;
    sts1[NUM_LINKS-1:0] = link_up;
    sts1[9:8]           = spy_state;
    sts1[10 +: PW]      = spy_ptr;
    rdata = 32'd0;
    if (bus.axi_raddr[9]) begin
      if ({23'd0, bus.axi_raddr[8:0]} < 32'(SPY_DEPTH))
        rdata = {13'd0, spy_ram[bus.axi_raddr[AW-1:0]]};
    end else begin
      case (bus.axi_raddr)
        10'h000: rdata = {26'd0, spy_mode, 1'b0, spy_sel};
        10'h001: rdata = {30'd0, ctl1};
        10'h010: rdata = 32'hbeef_0004;
        10'h011: rdata = sts1;
        default: begin
          if (bus.axi_raddr[9:4] == 6'h02) begin
            for (int i = 0; i < NUM_LINKS; i++) begin
              if (bus.axi_raddr[3:1] == 3'(i))
                rdata = bus.axi_raddr[0] ? wrd_cnt[i] : err_cnt[i];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_link_monitor.sv
// Directed bench for ts_link_monitor: handshakes, counters, lock and spy modes
// on an 8-link, 16-deep, LOCK_COUNT=4 instance.
module tb_ts_link_monitor;
  logic         axi_clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] rx_d = '0;
  logic [15:0]  rx_k = '0;
  logic [7:0]   rx_err = '0;
  logic [7:0]   rx_valid = '0;
  logic [7:0]   link_up;
  int           n_vec = 0;
  int           n_bad = 0;
  logic [31:0]  rv;
  logic [7:0][31:0] frc;

  ts_link_monitor_if bus ();

  ts_link_monitor #(.NUM_LINKS(8), .SPY_DEPTH(16), .LOCK_COUNT(4)) dut (
    .axi_clk  (axi_clk),
    .reset    (reset),
    .rx_d     (rx_d),
    .rx_k     (rx_k),
    .rx_err   (rx_err),
    .rx_valid (rx_valid),
    .link_up  (link_up),
    .bus      (bus)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    bus.axi_waddr = a;
    bus.axi_din   = d;
    bus.axi_wstr  = 1'b1;
    do begin @(negedge axi_clk); n++; end while (!bus.axi_wack && n < 10);
    chk("wr_ack", {31'd0, bus.axi_wack}, 32'd1);
    bus.axi_wstr = 1'b0;
    @(negedge axi_clk);
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    int n = 0;
    bus.axi_raddr = a;
    bus.axi_rstr  = 1'b1;
    do begin @(negedge axi_clk); n++; end while (!bus.axi_rack && n < 10);
    d = bus.axi_dout;
    if (!bus.axi_rack) chk("rd_ack", {31'd0, bus.axi_rack}, 32'd1);
    bus.axi_rstr = 1'b0;
    @(negedge axi_clk);
  endtask

  task automatic rchk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic word(input int l, input logic [15:0] d, input logic [1:0] k, input logic e);
    rx_d[16*l +: 16] = d;
    rx_k[2*l +: 2]   = k;
    rx_err[l]        = e;
    rx_valid[l]      = 1'b1;
    @(negedge axi_clk);
    rx_valid[l] = 1'b0;
    rx_err[l]   = 1'b0;
  endtask

  initial begin
    bus.axi_wstr = 1'b0; bus.axi_rstr = 1'b0;
    bus.axi_waddr = '0; bus.axi_raddr = '0; bus.axi_din = '0;
    repeat (3) @(negedge axi_clk);
    reset = 1'b0;
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_wack", {31'd0, bus.axi_wack}, 32'd0);
    chk("rst_rack", {31'd0, bus.axi_rack}, 32'd0);
    chk("rst_dout", bus.axi_dout, 32'd0);

    // write handshake edge by edge
    bus.axi_waddr = 10'h000; bus.axi_din = 32'h35; bus.axi_wstr = 1'b1;
    @(negedge axi_clk);
    chk("w_e1_wack", {31'd0, bus.axi_wack}, 32'd0);
    chk("w_e1_sel", {29'd0, dut.spy_sel}, 32'd0);
    @(negedge axi_clk);
    chk("w_e2_wack", {31'd0, bus.axi_wack}, 32'd0);
    chk("w_e2_sel", {29'd0, dut.spy_sel}, 32'd5);
    @(negedge axi_clk);
    chk("w_e3_wack", {31'd0, bus.axi_wack}, 32'd1);
    repeat (2) @(negedge axi_clk);
    chk("w_hold_wack", {31'd0, bus.axi_wack}, 32'd1);
    bus.axi_wstr = 1'b0;
    @(negedge axi_clk);
    chk("w_drop_wack", {31'd0, bus.axi_wack}, 32'd0);
    rchk("ctl0_rb", 10'h000, 32'h35);
    wr(10'h000, 32'h0);

    // read handshake edge by edge
    bus.axi_raddr = 10'h010; bus.axi_rstr = 1'b1;
    @(negedge axi_clk);
    chk("r_e1_dout", bus.axi_dout, 32'd0);
    chk("r_e1_rack", {31'd0, bus.axi_rack}, 32'd0);
    @(negedge axi_clk);
    chk("r_e2_dout", bus.axi_dout, 32'hbeef0004);
    @(negedge axi_clk);
    chk("r_e3_rack", {31'd0, bus.axi_rack}, 32'd0);
    @(negedge axi_clk);
    chk("r_e4_rack", {31'd0, bus.axi_rack}, 32'd1);
    bus.axi_rstr = 1'b0;
    @(negedge axi_clk);
    chk("r_drop_rack", {31'd0, bus.axi_rack}, 32'd0);
    chk("r_drop_dout", bus.axi_dout, 32'd0);

    rchk("rst_sts1", 10'h011, 32'd0);
    rchk("rst_ctl1", 10'h001, 32'd0);
    for (int i = 0; i < 16; i++) rchk($sformatf("rst_cnt%0d", i), 10'(32'h20 + i), 32'd0);
    rchk("unmapped", 10'h005, 32'd0);
    wr(10'h010, 32'h0);
    rchk("sts0_ro", 10'h010, 32'hbeef0004);

    // lock on link 1
    for (int n = 0; n < 3; n++) begin
      word(1, 16'(16'h1000 + n), 2'b00, 1'b0);
      chk("lock_pre", 32'(link_up), 32'h00);
    end
    word(1, 16'h1003, 2'b00, 1'b0);
    chk("lock_up", 32'(link_up), 32'h02);
    word(1, 16'h1004, 2'b00, 1'b1);
    chk("lock_err_drop", 32'(link_up), 32'h00);
    rchk("l1_err", 10'h022, 32'd1);
    rchk("l1_wrd", 10'h023, 32'd5);
    for (int n = 0; n < 3; n++) word(1, 16'h2000, 2'b00, 1'b0);
    chk("relock_pre", 32'(link_up), 32'h00);
    word(1, 16'h2000, 2'b00, 1'b0);
    chk("relock_up", 32'(link_up), 32'h02);

    // saturation on link 0
    frc = dut.wrd_cnt;
    frc[0] = 32'hFFFF_FFFD;
    force dut.wrd_cnt = frc;
    @(negedge axi_clk);
    release dut.wrd_cnt;
    for (int n = 0; n < 3; n++) word(0, 16'h0, 2'b00, 1'b0);
    rchk("l0_sat", 10'h021, 32'hFFFF_FFFF);

    // clear pulse lands on the edge after commit, together with a valid word
    bus.axi_waddr = 10'h001; bus.axi_din = 32'h2; bus.axi_wstr = 1'b1;
    repeat (2) @(negedge axi_clk);
    rx_valid[0] = 1'b1;
    @(negedge axi_clk);
    rx_valid[0] = 1'b0;
    chk("clr_wack", {31'd0, bus.axi_wack}, 32'd1);
    bus.axi_wstr = 1'b0;
    @(negedge axi_clk);
    chk("clr_keeps_lock", 32'(link_up), 32'h03);
    rchk("clr_l0_wrd", 10'h021, 32'd0);
    rchk("clr_l1_wrd", 10'h023, 32'd0);
    rchk("clr_l1_err", 10'h022, 32'd0);

    // spy mode 2 on link 0
    wr(10'h000, 32'h20);
    wr(10'h001, 32'h1);
    rchk("m2_armed", 10'h011, 32'h0103);
    for (int n = 0; n < 3; n++) word(0, 16'(16'hBC00 + n), 2'b01, 1'b0);
    rchk("m2_idle_k", 10'h011, 32'h0103);
    for (int n = 0; n < 5; n++) word(0, 16'(16'h1234 + n), 2'b00, 1'b0);
    rchk("m2_capt5", 10'h011, 32'h1603);
    for (int n = 5; n < 15; n++) word(0, 16'(16'h1234 + n), 2'b00, 1'b0);
    rchk("m2_capt15", 10'h011, 32'h3E03);
    word(0, 16'h1243, 2'b00, 1'b0);
    rchk("m2_done", 10'h011, 32'h4303);
    word(0, 16'h9999, 2'b00, 1'b0);
    rchk("m2_done_hold", 10'h011, 32'h4303);
    rchk("m2_w0", 10'h200, 32'h00001234);
    rchk("m2_w1", 10'h201, 32'h00001235);
    rchk("m2_w15", 10'h20F, 32'h00001243);
    rchk("spy_oob", 10'h210, 32'd0);

    // spy mode 1 on link 0
    wr(10'h000, 32'h10);
    wr(10'h001, 32'h1);
    for (int n = 0; n < 3; n++) word(0, 16'h5000, 2'b00, 1'b0);
    rchk("m1_no_trig", 10'h011, 32'h0103);
    word(0, 16'hABCD, 2'b00, 1'b1);
    rchk("m1_w0", 10'h200, 32'h0004ABCD);
    rchk("m1_sts1", 10'h011, 32'h0602);
    rchk("m1_l0_err", 10'h020, 32'd1);

    // re-arm mid-capture on link 7
    wr(10'h000, 32'h07);
    wr(10'h001, 32'h1);
    for (int n = 0; n < 3; n++) word(7, 16'(16'h7000 + n), 2'b10, 1'b0);
    rchk("l7_capt3", 10'h011, 32'h0E02);
    rchk("l7_w1", 10'h201, 32'h00027001);
    wr(10'h001, 32'h1);
    rchk("rearm_sts1", 10'h011, 32'h0102);
    word(0, 16'h1111, 2'b00, 1'b0);
    rchk("unsel_ignored", 10'h011, 32'h0102);
    word(7, 16'h7777, 2'b00, 1'b0);
    rchk("rearm_w0", 10'h200, 32'h00007777);
    rchk("rearm_capt1", 10'h011, 32'h0682);
    rchk("l7_wrd", 10'h02F, 32'd4);
    rchk("l7_err", 10'h02E, 32'd0);
    rchk("l9_err", 10'h032, 32'd0);
    rchk("l9_wrd", 10'h033, 32'd0);

    // reset in the middle of a capture
    reset = 1'b1;
    @(negedge axi_clk);
    reset = 1'b0;
    chk("rst2_link_up", 32'(link_up), 32'd0);
    rchk("rst2_sts1", 10'h011, 32'd0);
    rchk("rst2_ctl0", 10'h000, 32'd0);
    rchk("rst2_l7_wrd", 10'h02F, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
